alu_serial_ctrl: RTL and testbench

//  Bit-serial sequencer for the 1-bit ALU slice (ports A,B,ENA,ENB,INVA,F0,F1,Carry_in -> Out,Carry_out).

---
 rtl/alu_serial_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving one external combinational 1-bit ALU slice, LSB first.
// Optional feature macro: ALU_SERIAL_OVF_EN adds a signed-overflow flag output (ovf).
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             ena,
    input  logic             enb,
    input  logic             inva,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
`ifdef ALU_SERIAL_OVF_EN
    output logic             ovf,
`endif
    output logic             sl_a,
    output logic             sl_b,
    output logic             sl_ena,
    output logic             sl_enb,
    output logic             sl_inva,
    output logic             sl_f0,
    output logic             sl_f1,
    output logic             sl_cin,
    input  logic             sl_out,
    input  logic             sl_cout
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       op_q, op_d;
    logic             ena_q, ena_d;
    logic             enb_q, enb_d;
    logic             inva_q, inva_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             shifting_s;
`ifdef ALU_SERIAL_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Next-state and datapath computation for the sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        result_d = result_q;
        op_d     = op_q;
        ena_d    = ena_q;
        enb_d    = enb_q;
        inva_d   = inva_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
`ifdef ALU_SERIAL_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = {CNT_W{1'b0}};
                    a_sh_d  = a;
                    b_sh_d  = b;
                    op_d    = op;
                    ena_d   = ena;
                    enb_d   = enb;
                    inva_d  = inva;
                    carry_d = cin;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Operands shift right so bit 0 always faces the slice; result fills from the top.
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                res_sh_d = {sl_out, res_sh_q[WIDTH-1:1]};
                carry_d  = sl_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d  = ST_DONE;
                    result_d = {sl_out, res_sh_q[WIDTH-1:1]};
                    cout_d   = sl_cout;
                    zero_d   = ({sl_out, res_sh_q[WIDTH-1:1]} == {WIDTH{1'b0}});
`ifdef ALU_SERIAL_OVF_EN
                    // carry_q is the carry fed into the MSB during this last cycle.
                    ovf_d    = (op_q == 2'b11) ? (carry_q ^ sl_cout) : 1'b0;
`endif
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            a_sh_q   <= {WIDTH{1'b0}};
            b_sh_q   <= {WIDTH{1'b0}};
            res_sh_q <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
            op_q     <= 2'b00;
            ena_q    <= 1'b0;
            enb_q    <= 1'b0;
            inva_q   <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b1;
`ifdef ALU_SERIAL_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            result_q <= result_d;
            op_q     <= op_d;
            ena_q    <= ena_d;
            enb_q    <= enb_d;
            inva_q   <= inva_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
`ifdef ALU_SERIAL_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Output decode from registered state; the slice is held idle outside SHIFT.
    always_comb begin
        shifting_s = (state_q == ST_SHIFT);
        busy       = shifting_s;
        done       = (state_q == ST_DONE);
        result     = result_q;
        cout       = cout_q;
        zero       = zero_q;
`ifdef ALU_SERIAL_OVF_EN
        ovf        = ovf_q;
`endif
        if (shifting_s) begin
            sl_a    = a_sh_q[0];
            sl_b    = b_sh_q[0];
            sl_ena  = ena_q;
            sl_enb  = enb_q;
            sl_inva = inva_q;
            sl_f0   = op_q[0];
            sl_f1   = op_q[1];
            sl_cin  = carry_q;
        end else begin
            sl_a    = 1'b0;
            sl_b    = 1'b0;
            sl_ena  = 1'b0;
            sl_enb  = 1'b0;
            sl_inva = 1'b0;
            sl_f0   = 1'b0;
            sl_f1   = 1'b0;
            sl_cin  = 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (WIDTH=8) with a behavioural 1-bit ALU slice.
module tb_alu_serial_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, ena, enb, inva, cin;
    logic [1:0] op;
    logic [7:0] a, b, result;
    logic       busy, done, cout, zero;
    logic       sl_a, sl_b, sl_ena, sl_enb, sl_inva, sl_f0, sl_f1, sl_cin;
    logic       sl_out, sl_cout;
`ifdef ALU_SERIAL_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    alu_serial_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .ena(ena), .enb(enb),
        .inva(inva), .cin(cin), .a(a), .b(b), .busy(busy), .done(done),
        .result(result), .cout(cout), .zero(zero),
`ifdef ALU_SERIAL_OVF_EN
        .ovf(ovf),
`endif
        .sl_a(sl_a), .sl_b(sl_b), .sl_ena(sl_ena), .sl_enb(sl_enb),
        .sl_inva(sl_inva), .sl_f0(sl_f0), .sl_f1(sl_f1), .sl_cin(sl_cin),
        .sl_out(sl_out), .sl_cout(sl_cout)
    );

    always #5 clk = ~clk;

    // Behavioural model of the combinational 1-bit ALU slice.
    logic sa_s, sb_s;
    always_comb begin
        sa_s    = (sl_a & sl_ena) ^ sl_inva;
        sb_s    = sl_b & sl_enb;
        sl_cout = 1'b0;
        case ({sl_f1, sl_f0})
            2'b00: sl_out = sa_s & sb_s;
            2'b01: sl_out = sa_s | sb_s;
            2'b10: sl_out = ~sb_s;
            2'b11: begin
                sl_out  = sa_s ^ sb_s ^ sl_cin;
                sl_cout = (sa_s & sb_s) | (sl_cin & (sa_s ^ sb_s));
            end
            default: sl_out = 1'b0;
        endcase
    end

    typedef struct {
        logic [1:0] op;
        logic       ena, enb, inva, cin;
        logic [7:0] a, b;
        logic [7:0] res;
        logic       co, ov;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       co, zr, ov;
    } exp_t;

    vec_t vecs[8];
    exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic drive_start(input vec_t v);
        @(negedge clk);
        op = v.op; ena = v.ena; enb = v.enb; inva = v.inva; cin = v.cin;
        a = v.a; b = v.b; start = 1'b1;
        sb_q.push_back('{res: v.res, co: v.co, zr: (v.res == 8'h00), ov: v.ov});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Waits for done, counts cycles from the start edge, and scores against the queue head.
    task automatic wait_and_score(input string tag, input int corrupt_cyc);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({tag, " busy@1"}, {63'd0, busy}, 64'd1);
            if (cyc == corrupt_cyc) begin
                a = 8'hAA; b = 8'h55; op = 2'b01; start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
                @(negedge clk);
                cyc++;
            end
            if (done || cyc > 30) break;
        end
        e = sb_q.pop_front();
        check({tag, " latency"}, 64'(cyc), 64'd9);
        check({tag, " result"}, {56'd0, result}, {56'd0, e.res});
        check({tag, " cout"}, {63'd0, cout}, {63'd0, e.co});
        check({tag, " zero"}, {63'd0, zero}, {63'd0, e.zr});
`ifdef ALU_SERIAL_OVF_EN
        check({tag, " ovf"}, {63'd0, ovf}, {63'd0, e.ov});
`endif
        @(negedge clk);
        check({tag, " done pulse"}, {62'd0, done, busy}, 64'd0);
        check({tag, " hold"}, {56'd0, result}, {56'd0, e.res});
    endtask

    initial begin
        vecs[0] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0};
        vecs[1] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 8'h10, 8'h0D, 1'b1, 1'b0};
        vecs[3] = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vecs[4] = '{2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0};
        vecs[5] = '{2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 8'hF0, 8'h0F, 8'hF0, 1'b0, 1'b0};
        vecs[6] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[7] = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 8'h0A, 8'h0B, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; op = 2'b00; ena = 1'b0; enb = 1'b0;
        inva = 1'b0; cin = 1'b0; a = 8'h00; b = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy/done", {62'd0, busy, done}, 64'd0);
        check("reset result", {56'd0, result}, 64'd0);
        check("reset cout/zero", {62'd0, cout, zero}, 64'd1);
        check("reset slice", {56'd0, sl_a, sl_b, sl_ena, sl_enb, sl_inva, sl_f0, sl_f1, sl_cin}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            drive_start(vecs[i]);
            wait_and_score($sformatf("vec%0d", i), 0);
        end

        // Start pulsed with new operands at busy cycle 3 must be ignored.
        drive_start(vecs[0]);
        wait_and_score("ignore start", 3);

        // Reset at busy cycle 4 aborts with no done pulse.
        drive_start(vecs[4]);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        void'(sb_q.pop_front());
        @(negedge clk);
        check("abort busy/done", {62'd0, busy, done}, 64'd0);
        check("abort result", {56'd0, result}, 64'd0);
        check("abort cout/zero", {62'd0, cout, zero}, 64'd1);
        check("abort slice ena", {62'd0, sl_ena, sl_enb}, 64'd0);
        begin
            logic seen;
            seen = 1'b0;
            repeat (12) begin
                @(negedge clk);
                seen = seen | done;
            end
            check("abort no done", {63'd0, seen}, 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
